cu_vertex_cache_arbiter: RTL and testbench
==========================================

CU_VERTEX_CACHE_ARBITER -- requirements
Module: cu_vertex_cache_arbiter

Interface
REQ-001 Parameter NUM_REQUESTERS, default 4: number of CU requesters sharing one vertex cache (2..8).
REQ-002 Parameter ID_FIFO_DEPTH, default 16: outstanding-request capacity (power of two).
REQ-003 clock  input  1  clock, all state on rising edge.
REQ-004 rstn_in  input  1  reset, asynchronous, active-low.
REQ-005 enabled_in  input  1  arbitration enable.
REQ-006 request_in[NUM_REQUESTERS]  input  CommandBufferLine  per-requester read command (valid+payload), held until granted.
REQ-007 cache_status_in  input  BufferStatus  cache command-buffer status; alm_full used.
REQ-008 response_in  input  ResponseBufferLine  in-order cache response.
REQ-009 grant_out  output  NUM_REQUESTERS  one-hot, one cycle per accepted request.
REQ-010 command_out  output  CommandBufferLine  registered command to cache.
REQ-011 response_out[NUM_REQUESTERS]  output  ResponseBufferLine  routed response.
REQ-012 outstanding_out  output  $clog2(ID_FIFO_DEPTH)+1  in-flight count.
REQ-013 error_out  output  1  sticky: response with no outstanding request.
REQ-014 idle_out  output  1  high in IDLE with outstanding_out==0.

Function
REQ-015 FSM states IDLE, ARB, STALL, DRAIN; IDLE->ARB when enabled_in=1.
REQ-016 ARB: round-robin; search starts at (last_grant+1) mod NUM_REQUESTERS; lowest index from that point wins.
REQ-017 At most one grant per cycle; grant_out and command_out.valid asserted together one cycle after the arbitration decision (latency 1).
REQ-018 command_out.payload = winner's request_in payload, unchanged.
REQ-019 Each grant pushes the winner index into an in-order ID FIFO; last_grant updated to winner.
REQ-020 ARB->STALL when cache_status_in.alm_full=1 or ID FIFO full; no grant issued in STALL; STALL->ARB when both clear.
REQ-021 ARB or STALL -> DRAIN when enabled_in=0; DRAIN issues no grants, continues routing responses; DRAIN->IDLE when outstanding_out==0.
REQ-022 response_in.valid pops ID FIFO head; response_out[head] = response_in one cycle later; all other response_out valid=0.
REQ-023 Simultaneous grant and response in same cycle: push and pop both occur, outstanding_out unchanged.
REQ-024 Response with empty ID FIFO: dropped, no response_out valid, error_out set until reset.
REQ-025 FIFO pointers wrap modulo ID_FIFO_DEPTH; full = count==ID_FIFO_DEPTH.
REQ-026 No requester valid in ARB: no grant, last_grant unchanged.

Reset
REQ-027 rstn_in low asynchronously: FSM=IDLE, last_grant=NUM_REQUESTERS-1, FIFO empty, grant_out=0, command_out=0, all response_out=0, outstanding_out=0, error_out=0, idle_out=1.
REQ-028 Reset mid-operation discards all in-flight IDs; responses arriving after release with empty FIFO follow REQ-024.
REQ-029 Reset deassertion synchronised internally by one register stage; first grant no earlier than 2 cycles after release.

Configuration
REQ-030 Macro VERTEX_CACHE_ARB_STATS_EN: when defined, per-requester 32-bit saturating grant counters and a 32-bit stall-cycle counter exist, output on grant_count_out[NUM_REQUESTERS] and stall_count_out, cleared by reset.
REQ-031 Without VERTEX_CACHE_ARB_STATS_EN: counters and their ports absent; all other behaviour identical.

Verification
REQ-032 All 4 requesters valid continuously, enabled_in=1 -> grants 0,1,2,3,0,1... one per cycle, command_out payloads match.
REQ-033 Only requester 2 valid, 5 cycles -> 5 consecutive grants to 2; responses return to response_out[2] only, 1-cycle latency.
REQ-034 alm_full=1 for 10 cycles mid-stream -> zero grants during those cycles; resumes at next RR index after release.
REQ-035 ID_FIFO_DEPTH=16, 16 grants without responses -> STALL, outstanding_out=16; one response -> one new grant, count stays 16.
REQ-036 Response with outstanding_out=0 -> no response_out valid, error_out=1 until rstn_in low.
REQ-037 enabled_in dropped with 3 outstanding -> DRAIN, no grants, 3 responses routed, then IDLE, idle_out=1.

Source files
------------

// File: rtl/cu_vertex_cache_arbiter.sv
// cu_vertex_cache_arbiter: round-robin arbiter letting several compute-unit
// requesters share one vertex cache. Each accepted request is forwarded as a
// registered command and its requester index is queued in an in-order ID FIFO
// so that in-order cache responses can be routed back to the right requester.
//
// Optional build macro VERTEX_CACHE_ARB_STATS_EN adds per-requester saturating
// grant counters and a stall-cycle counter (grant_count_out, stall_count_out).

package cu_vertex_cache_pkg;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] payload;
  } CommandBufferLine;

  typedef struct packed {
    logic alm_full;
    logic full;
    logic empty;
  } BufferStatus;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } ResponseBufferLine;
endpackage

module cu_vertex_cache_arbiter
  import cu_vertex_cache_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int ID_FIFO_DEPTH  = 16
) (
  input  logic                             clock,
  input  logic                             rstn_in,
  input  logic                             enabled_in,
  input  CommandBufferLine                 request_in [NUM_REQUESTERS],
  input  BufferStatus                      cache_status_in,
  input  ResponseBufferLine                response_in,
  output logic [NUM_REQUESTERS-1:0]        grant_out,
  output CommandBufferLine                 command_out,
  output ResponseBufferLine                response_out [NUM_REQUESTERS],
  output logic [$clog2(ID_FIFO_DEPTH):0]   outstanding_out,
  output logic                             error_out,
  output logic                             idle_out
`ifdef VERTEX_CACHE_ARB_STATS_EN
  ,
  output logic [31:0]                      grant_count_out [NUM_REQUESTERS],
  output logic [31:0]                      stall_count_out
`endif
);

  localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int PTR_W = $clog2(ID_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state, state_next;

  logic                      rst_done_p0;
  logic [IDX_W-1:0]          last_grant;
  logic [IDX_W-1:0]          winner;
  logic [IDX_W-1:0]          cand;
  logic                      found;
  logic                      arb_active;
  logic                      grant_fire;

  logic [IDX_W-1:0]          fifo_mem [ID_FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          count;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic [IDX_W-1:0]          head;
  logic                      stall_cond;

  logic [NUM_REQUESTERS-1:0] grant_p1;
  CommandBufferLine          command_p1;
  ResponseBufferLine         resp_p1 [NUM_REQUESTERS];
  logic                      error_flag;

  // Only alm_full steers the arbiter; the remaining status bits are ignored.
  logic unused_status;
  assign unused_status = cache_status_in.full ^ cache_status_in.empty;

  assign fifo_full  = (count == CNT_W'(ID_FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign stall_cond = cache_status_in.alm_full | fifo_full;
  assign head       = fifo_mem[rd_ptr];
  assign push       = grant_fire;
  assign pop        = response_in.valid & ~fifo_empty;

  // Release synchroniser: the FSM may leave IDLE only once this stage is set.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) rst_done_p0 <= 1'b0;
    else          rst_done_p0 <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next-state logic; disabling takes priority over stalling.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rst_done_p0 && enabled_in) state_next = ARB;
      ARB: begin
        if (!enabled_in)     state_next = DRAIN;
        else if (stall_cond) state_next = STALL;
      end
      STALL: begin
        if (!enabled_in)      state_next = DRAIN;
        else if (!stall_cond) state_next = ARB;
      end
      DRAIN:   if (fifo_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: a grant may only be decided in ARB with no stall or disable pending.
  always_comb begin
    arb_active = (state == ARB) && enabled_in && !stall_cond;
    idle_out   = (state == IDLE) && fifo_empty;
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    cand   = last_grant;
    for (int i = 1; i <= NUM_REQUESTERS; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_REQUESTERS);
      if (!found && request_in[cand].valid) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    grant_fire = arb_active && found;
  end

  // ---- stage p1: registered grant / command, round-robin pointer ----
  // Register the winning grant and its command together so they leave in the same cycle.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      grant_p1   <= '0;
      command_p1 <= '0;
      last_grant <= IDX_W'(NUM_REQUESTERS - 1);
    end else begin
      grant_p1   <= grant_fire ? (NUM_REQUESTERS'(1) << winner) : '0;
      command_p1 <= grant_fire ? request_in[winner] : '0;
      if (grant_fire) last_grant <= winner;
    end
  end

  // ID FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= winner;
  end

  // ID FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- stage p1: routed responses and sticky orphan-response error ----
  // Steer each response to the requester at the FIFO head; orphans are dropped and flagged.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      for (int i = 0; i < NUM_REQUESTERS; i++) resp_p1[i] <= '0;
      error_flag <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
        resp_p1[i] <= (pop && (head == IDX_W'(i))) ? response_in : '0;
      end
      if (response_in.valid && fifo_empty) error_flag <= 1'b1;
    end
  end

  assign grant_out       = grant_p1;
  assign command_out     = command_p1;
  assign response_out    = resp_p1;
  assign outstanding_out = count;
  assign error_out       = error_flag;

`ifdef VERTEX_CACHE_ARB_STATS_EN
  logic [31:0] grant_cnt [NUM_REQUESTERS];
  logic [31:0] stall_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating activity counters: grants per requester and cycles spent stalled.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      for (int i = 0; i < NUM_REQUESTERS; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
        if (grant_fire && (winner == IDX_W'(i))) grant_cnt[i] <= sat_inc(grant_cnt[i]);
      end
      if (state == STALL) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign grant_count_out = grant_cnt;
  assign stall_count_out = stall_cnt;
`endif

endmodule

// File: tb/tb_cu_vertex_cache_arbiter.sv
// Directed scoreboard bench for cu_vertex_cache_arbiter (4 requesters, 16-deep ID FIFO).
module tb_cu_vertex_cache_arbiter;
  import cu_vertex_cache_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 16;

  logic              clock = 1'b0;
  logic              rstn;
  logic              enabled;
  CommandBufferLine  request [N];
  BufferStatus       cache_status;
  ResponseBufferLine response;
  logic [N-1:0]      grant;
  CommandBufferLine  command;
  ResponseBufferLine response_routed [N];
  logic [4:0]        outstanding;
  logic              error;
  logic              idle;

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] val;
  } exp_t;

  exp_t        gq [$];
  exp_t        rq [$];
  int          model_ids [$];
  int          last_model;
  logic [31:0] cur_base;
  int          vectors;
  int          miscompares;

  cu_vertex_cache_arbiter #(
    .NUM_REQUESTERS(N),
    .ID_FIFO_DEPTH (DEPTH)
  ) dut (
    .clock          (clock),
    .rstn_in        (rstn),
    .enabled_in     (enabled),
    .request_in     (request),
    .cache_status_in(cache_status),
    .response_in    (response),
    .grant_out      (grant),
    .command_out    (command),
    .response_out   (response_routed),
    .outstanding_out(outstanding),
    .error_out      (error),
    .idle_out       (idle)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every grant and routed response against the expectation queues.
  task automatic sample();
    exp_t e;
    if (grant !== '0) begin
      if (gq.size() == 0) check("unexpected_grant", 64'(grant), 64'(0));
      else begin
        e = gq.pop_front();
        check("grant", 64'(grant), 64'(1) << e.idx);
        check("cmd_valid", 64'(command.valid), 64'(1));
        check("cmd_payload", 64'(command.payload), 64'(e.val));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (response_routed[i].valid !== 1'b0) begin
        if (rq.size() == 0) check("unexpected_resp", 64'(i), 64'(255));
        else begin
          e = rq.pop_front();
          check("resp_route", 64'(i), 64'(e.idx));
          check("resp_data", 64'(response_routed[i].data), 64'(e.val));
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    sample();
  endtask

  task automatic set_requests(input logic [N-1:0] mask, input logic [31:0] base);
    cur_base = base;
    for (int i = 0; i < N; i++) begin
      request[i].valid   = mask[i];
      request[i].payload = base + 32'(i);
    end
  endtask

  task automatic expect_grant(input int idx);
    gq.push_back('{idx: 8'(idx), val: cur_base + 32'(idx)});
    model_ids.push_back(idx);
    last_model = idx;
  endtask

  task automatic expect_rr(input int n);
    for (int k = 0; k < n; k++) expect_grant((last_model + 1) % N);
  endtask

  task automatic run_grants(input int budget);
    for (int c = 0; c < budget && gq.size() != 0; c++) cyc();
    if (gq.size() != 0) begin
      check("grant_timeout", 64'(gq.size()), 64'(0));
      gq.delete();
    end
  endtask

  task automatic respond(input logic [31:0] data);
    response.valid = 1'b1;
    response.data  = data;
    if (model_ids.size() != 0) rq.push_back('{idx: 8'(model_ids.pop_front()), val: data});
    cyc();
    response = '0;
    check("resp_latency", 64'(rq.size()), 64'(0));
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    last_model   = N - 1;
    rstn         = 1'b0;
    enabled      = 1'b0;
    cache_status = '0;
    response     = '0;
    set_requests('0, 32'h0);

    // Reset state
    cyc();
    cyc();
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_command", 64'(command), 64'(0));
    for (int i = 0; i < N; i++) check("rst_resp", 64'(response_routed[i]), 64'(0));
    check("rst_outstanding", 64'(outstanding), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    check("rst_idle", 64'(idle), 64'(1));

    // All requesters valid: strict 0,1,2,3 rotation, first grant two cycles after release
    rstn    = 1'b1;
    enabled = 1'b1;
    set_requests(4'b1111, 32'hA000_0000);
    cyc();
    check("no_early_grant", 64'(grant), 64'(0));
    cyc();
    check("no_early_grant", 64'(grant), 64'(0));
    expect_rr(8);
    run_grants(12);
    set_requests('0, 32'hA000_0000);
    cyc();
    check("outstanding_8", 64'(outstanding), 64'(8));
    check("idle_busy", 64'(idle), 64'(0));
    for (int k = 0; k < 8; k++) respond(32'h5000 + 32'(k));
    check("outstanding_0", 64'(outstanding), 64'(0));

    // Only requester 2: back-to-back grants, responses go to port 2 only
    set_requests(4'b0100, 32'hB000_0000);
    for (int k = 0; k < 5; k++) expect_grant(2);
    run_grants(8);
    set_requests('0, 32'hB000_0000);
    cyc();
    check("outstanding_5", 64'(outstanding), 64'(5));
    for (int k = 0; k < 5; k++) respond(32'h6000 + 32'(k));

    // alm_full window: no grants, then resume at the next round-robin index
    set_requests(4'b1111, 32'hC000_0000);
    expect_rr(3);
    run_grants(6);
    cache_status.alm_full = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("almfull_no_grant", 64'(grant), 64'(0));
    end
    cache_status.alm_full = 1'b0;
    expect_rr(3);
    run_grants(6);
    set_requests('0, 32'hC000_0000);
    cyc();
    check("outstanding_6", 64'(outstanding), 64'(6));
    for (int k = 0; k < 6; k++) respond(32'h6100 + 32'(k));

    // Fill the ID FIFO: stall at 16, one response frees exactly one grant
    set_requests(4'b1111, 32'hD000_0000);
    expect_rr(16);
    run_grants(20);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("full_no_grant", 64'(grant), 64'(0));
    end
    check("outstanding_full", 64'(outstanding), 64'(16));
    expect_rr(1);
    respond(32'h7777);
    run_grants(6);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("refull_no_grant", 64'(grant), 64'(0));
    end
    check("outstanding_refull", 64'(outstanding), 64'(16));
    set_requests('0, 32'hD000_0000);
    for (int k = 0; k < 16; k++) respond(32'h7000 + 32'(k));
    check("outstanding_drained", 64'(outstanding), 64'(0));

    // Disable with 3 outstanding: DRAIN routes them, then IDLE
    set_requests(4'b1111, 32'hE000_0000);
    expect_rr(3);
    run_grants(6);
    enabled = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("drain_no_grant", 64'(grant), 64'(0));
    end
    check("drain_outstanding", 64'(outstanding), 64'(3));
    check("drain_not_idle", 64'(idle), 64'(0));
    for (int k = 0; k < 3; k++) respond(32'h8000 + 32'(k));
    cyc();
    cyc();
    check("idle_after_drain", 64'(idle), 64'(1));
    check("drain_empty", 64'(outstanding), 64'(0));

    // Orphan response: dropped, sticky error until reset
    set_requests('0, 32'h0);
    check("error_clear", 64'(error), 64'(0));
    respond(32'hDEAD);
    check("error_set", 64'(error), 64'(1));
    for (int k = 0; k < 3; k++) cyc();
    check("error_sticky", 64'(error), 64'(1));
    rstn = 1'b0;
    #1;
    check("error_reset", 64'(error), 64'(0));
    check("idle_reset", 64'(idle), 64'(1));
    model_ids.delete();
    last_model = N - 1;

    // Reset mid-operation discards in-flight IDs
    cyc();
    rstn    = 1'b1;
    enabled = 1'b1;
    set_requests(4'b0010, 32'hF000_0000);
    expect_grant(1);
    expect_grant(1);
    run_grants(8);
    set_requests('0, 32'hF000_0000);
    cyc();
    check("pre_reset_outstanding", 64'(outstanding), 64'(2));
    rstn = 1'b0;
    #1;
    check("midrst_outstanding", 64'(outstanding), 64'(0));
    check("midrst_grant", 64'(grant), 64'(0));
    check("midrst_cmd_valid", 64'(command.valid), 64'(0));
    model_ids.delete();
    cyc();
    rstn = 1'b1;
    cyc();
    cyc();
    respond(32'hBEEF);
    check("post_reset_orphan_error", 64'(error), 64'(1));
    check("post_reset_outstanding", 64'(outstanding), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
